demux4_bit5_router: RTL

DEMUX4_BIT5_ROUTER -- requirements
Module: demux4_bit5_router

---
 rtl/demux4_bit5_router.sv | 108 ++++++++++
 1 files changed

// File: rtl/demux4_bit5_router.sv
// demux4_bit5_router: routes each accepted input word into one of four
// one-entry holding registers. The registers drain independently, and each
// channel keeps an 8-bit count of the words it has delivered.
//
// Per-channel FSM
//   state | meaning
//   EMPTY | holding register has no word, OUT_VALID[n]=0
//   FULL  | holding register holds a word, OUT_VALID[n]=1
module demux4_bit5_router #(
  parameter int DATA_W = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [1:0]            CONTROL,
  input  logic [DATA_W-1:0]     IN,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [4*DATA_W-1:0]   OUT_DATA,
  output logic [3:0]            OUT_VALID,
  input  logic [3:0]            OUT_READY,
  output logic [31:0]           DELIV_CNT
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  ch_state_t         state_q [4];
  ch_state_t         state_d [4];
  logic [DATA_W-1:0] data_q  [4];
  logic [7:0]        cnt_q   [4];
  logic [3:0]        load;
  logic [3:0]        drain;
  logic              accept;

  // Ready depends on the addressed channel only. A full channel that is
  // draining this cycle can take a new word, which gives 1 word per cycle.
  always_comb begin
    IN_READY = 1'b0;
    if (!RESET) begin
      IN_READY = (state_q[CONTROL] == EMPTY) || OUT_READY[CONTROL];
    end
    accept = IN_VALID && IN_READY;
  end

  // Next-state and per-channel load/drain strobes. An accept takes priority
  // over a drain on the same channel, so the channel stays FULL.
  always_comb begin
    load  = 4'b0000;
    drain = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      state_d[n] = state_q[n];
      drain[n]   = (state_q[n] == FULL) && OUT_READY[n];
      if (accept && (CONTROL == 2'(n))) begin
        load[n]    = 1'b1;
        state_d[n] = FULL;
      end else if (drain[n]) begin
        state_d[n] = EMPTY;
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int n = 0; n < 4; n++) state_q[n] <= EMPTY;
    end else begin
      for (int n = 0; n < 4; n++) state_q[n] <= state_d[n];
    end
  end

  // Holding registers keep the last word after draining and are only
  // rewritten on a load.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int n = 0; n < 4; n++) data_q[n] <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (load[n]) data_q[n] <= IN;
      end
    end
  end

  // Delivered-word counters. They wrap silently at 256.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int n = 0; n < 4; n++) cnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (drain[n]) cnt_q[n] <= cnt_q[n] + 8'd1;
      end
    end
  end

  // Flatten the per-channel state onto the output buses.
  always_comb begin
    OUT_DATA  = '0;
    OUT_VALID = 4'b0000;
    DELIV_CNT = '0;
    for (int n = 0; n < 4; n++) begin
      OUT_DATA[n*DATA_W +: DATA_W] = data_q[n];
      OUT_VALID[n]                 = (state_q[n] == FULL);
      DELIV_CNT[8*n +: 8]          = cnt_q[n];
    end
  end

endmodule
